// File: rtl/digit_entry_pkg.sv
// Shared types and constants for the six-digit BCD entry controller.
// Holds the FSM state encoding, digit geometry and button indices.
package digit_entry_pkg;

   localparam int NUM_DIGITS = 6;
   localparam int BCD_W      = 4;
   localparam int VALUE_W    = 20;
   localparam int IDX_W      = 3;

   localparam int NUM_BTNS   = 5;
   localparam int BTN_UP     = 0;
   localparam int BTN_DOWN   = 1;
   localparam int BTN_LEFT   = 2;
   localparam int BTN_RIGHT  = 3;
   localparam int BTN_CENTER = 4;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;

   // One BCD step up or down, wrapping within 0..9 with no carry out.
   function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] d,
                                                  input logic            inc);
      logic [BCD_W-1:0] r;
      if (inc) r = (d >= 4'd9) ? 4'd0 : d + 4'd1;
      else     r = (d == 4'd0) ? 4'd9 : d - 4'd1;
      return r;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// Pushbutton front end: 2-flop sync, stable-count debounce, rising-edge event pulse.
// Event lags the raw press by 2 + DEBOUNCE_CYCLES cycles; no backpressure, events are fire-and-forget.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1000000
`ifdef DIGIT_ENTRY_REPEAT_EN
  ,parameter int HOLD_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000,
   parameter bit REPEAT_EN       = 1'b0
`endif
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic evt
);

   localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            sync1;
   logic            sync2;
   logic            db;
   logic            db_q;
   logic [DB_W-1:0] cnt;
   logic            rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         db    <= 1'b0;
         db_q  <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         db_q  <= db;
         // Any cycle where the input agrees with the debounced level restarts the count.
         if (sync2 == db) begin
            cnt <= '0;
         end else if (cnt == DB_LAST) begin
            db  <= sync2;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign rise = db & ~db_q;

`ifdef DIGIT_ENTRY_REPEAT_EN
   logic rep_evt;

   if (REPEAT_EN) begin : g_repeat
      localparam int MAX_C = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
      localparam int RPT_W = (MAX_C < 2) ? 1 : $clog2(MAX_C + 1);
      localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_CYCLES - 1);
      localparam logic [RPT_W-1:0] RPT_LAST  = RPT_W'(REPEAT_CYCLES - 1);

      logic [RPT_W-1:0] rcnt;
      logic             rep_on;

      // First repeat fires HOLD+REPEAT cycles after the press event, then every REPEAT.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rcnt    <= '0;
            rep_on  <= 1'b0;
            rep_evt <= 1'b0;
         end else if (!db || rise) begin
            rcnt    <= '0;
            rep_on  <= 1'b0;
            rep_evt <= 1'b0;
         end else if (!rep_on && rcnt == HOLD_LAST) begin
            rcnt    <= '0;
            rep_on  <= 1'b1;
            rep_evt <= 1'b0;
         end else if (rep_on && rcnt == RPT_LAST) begin
            rcnt    <= '0;
            rep_evt <= 1'b1;
         end else begin
            rcnt    <= rcnt + 1'b1;
            rep_evt <= 1'b0;
         end
      end
   end else begin : g_no_repeat
      assign rep_evt = 1'b0;
   end

   assign evt = rise | rep_evt;
`else
   assign evt = rise;
`endif

endmodule

// File: rtl/digit_entry_controller.sv
// Six-digit BCD editor driven by five debounced buttons; center commits via a 6-cycle BCD->binary shift-add.
// Edits land 1 cycle after an event, value_valid 7 cycles after center; events during busy are dropped.
// Optional up/down auto-repeat: define DIGIT_ENTRY_REPEAT_EN.
module digit_entry_controller
   import digit_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int HOLD_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        btn_up,
   input  logic                        btn_down,
   input  logic                        btn_left,
   input  logic                        btn_right,
   input  logic                        btn_center,
   output logic [NUM_DIGITS*BCD_W-1:0] edit_bcd,
   output logic [IDX_W-1:0]            cursor,
   output logic [VALUE_W-1:0]          value,
   output logic                        value_valid,
   output logic                        busy
);

   logic [NUM_BTNS-1:0] btn_raw;
   logic [NUM_BTNS-1:0] evt;

   assign btn_raw = {btn_center, btn_right, btn_left, btn_down, btn_up};

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
`ifdef DIGIT_ENTRY_REPEAT_EN
      button_debouncer #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_CYCLES     (HOLD_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES),
         .REPEAT_EN       ((i == BTN_UP) || (i == BTN_DOWN))
      ) u_db (
         .clk   (clk),
         .rst_n (rst_n),
         .btn   (btn_raw[i]),
         .evt   (evt[i])
      );
`else
      button_debouncer #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
         .clk   (clk),
         .rst_n (rst_n),
         .btn   (btn_raw[i]),
         .evt   (evt[i])
      );
`endif
   end

   state_t                               state, state_next;
   logic [NUM_DIGITS-1:0][BCD_W-1:0]     digits, digits_next;
   logic [IDX_W-1:0]                     cursor_next;
   logic [IDX_W-1:0]                     idx, idx_next;
   logic [VALUE_W-1:0]                   acc, acc_next, acc_step;
   logic [VALUE_W-1:0]                   value_next;
   logic                                 value_valid_next;

   // acc*10 + digit as shift-add; 999999 fits in 20 bits so no overflow path exists.
   assign acc_step = (acc << 3) + (acc << 1) + VALUE_W'(digits[idx]);

   always_comb begin
      state_next       = state;
      digits_next      = digits;
      cursor_next      = cursor;
      idx_next         = idx;
      acc_next         = acc;
      value_next       = value;
      value_valid_next = 1'b0;

      case (state)
         IDLE: begin
            // Fixed priority: only the highest same-cycle event is acted on.
            if (evt[BTN_CENTER]) begin
               state_next = CONVERT;
               idx_next   = LAST_IDX;
               acc_next   = '0;
            end else if (evt[BTN_UP]) begin
               digits_next[cursor] = bcd_step(digits[cursor], 1'b1);
            end else if (evt[BTN_DOWN]) begin
               digits_next[cursor] = bcd_step(digits[cursor], 1'b0);
            end else if (evt[BTN_LEFT]) begin
               if (cursor != LAST_IDX) cursor_next = cursor + 1'b1;
            end else if (evt[BTN_RIGHT]) begin
               if (cursor != '0) cursor_next = cursor - 1'b1;
            end
         end
         CONVERT: begin
            acc_next = acc_step;
            if (idx == '0) begin
               state_next       = DONE;
               value_next       = acc_step;
               value_valid_next = 1'b1;
            end else begin
               idx_next = idx - 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         digits      <= '0;
         cursor      <= '0;
         idx         <= '0;
         acc         <= '0;
         value       <= '0;
         value_valid <= 1'b0;
      end else begin
         state       <= state_next;
         digits      <= digits_next;
         cursor      <= cursor_next;
         idx         <= idx_next;
         acc         <= acc_next;
         value       <= value_next;
         value_valid <= value_valid_next;
      end
   end

   assign edit_bcd = digits;
   assign busy     = (state != IDLE);

endmodule

// File: doc/digit_entry_controller.md
DIGIT_ENTRY_CONTROLLER -- requirements
Module: digit_entry_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, cycles an input must be stable before acceptance (10 ms at 100 MHz).
REQ-002 SHALL have parameter HOLD_CYCLES, default 50000000, hold time before auto-repeat starts (used only with REPEAT_EN).
REQ-003 SHALL have parameter REPEAT_CYCLES, default 10000000, auto-repeat period (used only with REPEAT_EN).
REQ-004 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports btn_up, btn_down, btn_left, btn_right, btn_center  input  1 each  raw asynchronous pushbuttons, active-high.
REQ-007 SHALL have port edit_bcd  output  24  six BCD edit digits; digit0 is [3:0], the least significant digit.
REQ-008 SHALL have port cursor  output  3  edited digit index, 0..5.
REQ-009 SHALL have port value  output  20  committed binary value, 0..999999.
REQ-010 SHALL have port value_valid  output  1  one-cycle pulse when value updates.
REQ-011 SHALL have port busy  output  1  high while a commit conversion is in progress.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer, then a debouncer; the debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-013 SHALL produce a one-cycle event on each debounced rising edge; falling edges produce no event.
REQ-014 SHALL, on same-cycle events, act only on the highest priority (center > up > down > left > right) and discard the rest.
REQ-015 Up SHALL increment the digit at cursor, wrapping 9->0 with no carry into other digits.
REQ-016 Down SHALL decrement the digit at cursor, wrapping 0->9 with no borrow.
REQ-017 Left SHALL increment cursor, saturating at 5; right SHALL decrement cursor, saturating at 0.
REQ-018 Edits SHALL appear on edit_bcd/cursor on the cycle after the event.
REQ-019 SHALL use FSM states IDLE, CONVERT, DONE; center event in IDLE -> CONVERT with idx=5, acc=0.
REQ-020 In CONVERT, each cycle SHALL compute acc = acc*10 + digit[idx] (shift-add: (acc<<3)+(acc<<1)), 20-bit unsigned; after idx 0 -> DONE.
REQ-021 In DONE, value SHALL load acc and value_valid SHALL be high for exactly one cycle, then -> IDLE; value_valid rises 7 cycles after the center event cycle.
REQ-022 busy SHALL be high in CONVERT and DONE; all button events during busy SHALL be dropped, and edit_bcd SHALL stay frozen.
REQ-023 value SHALL hold its last committed value between commits; no overflow is possible (999999 < 2^20).

Reset
REQ-024 rst_n low SHALL asynchronously force edit_bcd=0, cursor=0, value=0, value_valid=0, busy=0, FSM=IDLE, debounced levels=0, and all counters to 0.
REQ-025 Reset during CONVERT SHALL abort the conversion; no value_valid SHALL follow release.
REQ-026 A button held through reset release SHALL generate one event after DEBOUNCE_CYCLES.

Configuration
REQ-027 With macro DIGIT_ENTRY_REPEAT_EN defined, up/down held continuously for HOLD_CYCLES after their event SHALL generate repeat events every REPEAT_CYCLES until release; left/right/center never repeat.
REQ-028 Without DIGIT_ENTRY_REPEAT_EN, each press SHALL yield exactly one event, and no repeat counters SHALL be synthesized.

Structure
REQ-029 Package digit_entry_pkg SHALL hold the FSM state enum, NUM_DIGITS=6, BCD_W=4, VALUE_W=20, and button index constants.
REQ-030 Sub-module button_debouncer (synchronizer, debounce counter, rising-edge event) SHALL be instantiated once per button.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5)
REQ-031 After reset: press up 3x, left, up 2x, center -> edit_bcd=24'h000023, value=23, value_valid one cycle, 7 cycles after the center event.
REQ-032 Cursor 0, digit 0, press down -> digit0=9; cursor at 5, press left -> cursor remains 5; at 0, press right -> remains 0.
REQ-033 Set all digits to 9, center -> value=999999 (20'hF423F); 2-cycle glitch on btn_up -> no edit.
REQ-034 Press up and left in the same cycle -> only up applied; press up during busy -> dropped, edit_bcd unchanged.
REQ-035 Assert rst_n low at CONVERT idx=3 -> value=0, busy=0, no value_valid after release.
REQ-036 With DIGIT_ENTRY_REPEAT_EN, hold up for 4+20+3*5 cycles -> digit increments 4 times; without the macro -> 1 time.
